// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - write-back arbiter merging pipeline writes and buffered load returns
//
// Purpose:
//   Drives the single write port of the 16x16 register file. Pipeline
//   write-back has priority and is never stalled. Load returns are queued in
//   a DEPTH-entry circular FIFO and drained on cycles with no pipeline write.
//   A pipeline write to register X kills every queued load to X
//   (write-after-write), and that includes a load pushed on the same edge.
//   A killed entry still drains through the FIFO, but it produces a bubble
//   instead of a write.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   pipe_we/dst/data pipeline write-back request (no backpressure)
//   ld_valid/ready   load-return handshake (ready = FIFO not full)
//   ld_dst/data      load-return destination and data
//   WriteReg         registered register-file write enable
//   DstReg/DstData   registered register-file write address/data
//   pend_mask        one bit per register targeted by a live FIFO entry
//   ld_count         FIFO occupancy, killed entries included

module rf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we,
  input  logic [3:0]    pipe_dst,
  input  logic [15:0]   pipe_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [3:0]    ld_dst,
  input  logic [15:0]   ld_data,
  output logic          WriteReg,
  output logic [3:0]    DstReg,
  output logic [15:0]   DstData,
  output logic [15:0]   pend_mask,
  output logic [CW-1:0] ld_count
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [3:0]    r_ld_dst  [DEPTH];
  logic [15:0]   r_ld_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_write_reg;
  logic [3:0]    r_dst_reg;
  logic [15:0]   r_dst_data;

  logic          w_pipe_wr;
  logic          w_push;
  logic          w_store;
  logic          w_pop;
  logic          w_push_live;
  logic          w_head_live;
  logic [15:0]   w_pend;

  // A write to R0 is discarded by the register file, so it never blocks
  // the FIFO and never kills anything.
  assign w_pipe_wr   = pipe_we && (pipe_dst != 4'd0);

  // Readiness depends on registered occupancy only. A full FIFO refuses a
  // push even when it pops in the same cycle.
  assign ld_ready    = (r_count < DEPTH_C);
  assign w_push      = ld_valid && ld_ready;
  assign w_store     = w_push && (ld_dst != 4'd0);
  assign w_pop       = !w_pipe_wr && (r_count != '0);

  // The pipeline write on this edge is younger than the incoming load.
  assign w_push_live = !(w_pipe_wr && (ld_dst == pipe_dst));
  assign w_head_live = r_live[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_live   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ld_dst[i]  <= 4'd0;
        r_ld_data[i] <= 16'd0;
      end
    end else begin
      // Kill every queued load to the pipeline destination. Slots that are
      // not occupied are already dead, so matching them has no effect.
      if (w_pipe_wr) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_ld_dst[i] == pipe_dst) begin
            r_live[i] <= 1'b0;
          end
        end
      end

      if (w_pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + AW'(1);
      end

      // If a push and a pop happen together, the FIFO is not full, so the
      // write slot is never the slot that is being popped.
      if (w_store) begin
        r_ld_dst[r_wr_ptr]  <= ld_dst;
        r_ld_data[r_wr_ptr] <= ld_data;
        r_live[r_wr_ptr]    <= w_push_live;
        r_wr_ptr            <= r_wr_ptr + AW'(1);
      end

      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write_reg <= 1'b0;
      r_dst_reg   <= 4'd0;
      r_dst_data  <= 16'd0;
    end else if (w_pipe_wr) begin
      r_write_reg <= 1'b1;
      r_dst_reg   <= pipe_dst;
      r_dst_data  <= pipe_data;
    end else if (w_pop && w_head_live) begin
      r_write_reg <= 1'b1;
      r_dst_reg   <= r_ld_dst[r_rd_ptr];
      r_dst_data  <= r_ld_data[r_rd_ptr];
    end else begin
      // An idle cycle or a killed head gives a bubble. Address and data
      // keep their previous values.
      r_write_reg <= 1'b0;
    end
  end

  // Derived from registered state only, so it changes on the same edge as
  // the push, kill or pop that causes the change.
  always_comb begin
    w_pend = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) begin
        w_pend[r_ld_dst[i]] = 1'b1;
      end
    end
  end

  assign pend_mask = w_pend;
  assign ld_count  = r_count;
  assign WriteReg  = r_write_reg;
  assign DstReg    = r_dst_reg;
  assign DstData   = r_dst_data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter

module tb_rf_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pipe_we = 1'b0;
  logic [3:0]    pipe_dst = 4'd0;
  logic [15:0]   pipe_data = 16'd0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [3:0]    ld_dst = 4'd0;
  logic [15:0]   ld_data = 16'd0;
  logic          WriteReg;
  logic [3:0]    DstReg;
  logic [15:0]   DstData;
  logic [15:0]   pend_mask;
  logic [CW-1:0] ld_count;

  int errors = 0;
  int checks = 0;
  logic [19:0] exp_q[$];

  rf_wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_dst(pipe_dst), .pipe_data(pipe_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dst(ld_dst), .ld_data(ld_data),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .pend_mask(pend_mask), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  // Monitor: every register-file write must match the next expected write.
  always @(negedge clk) begin
    if (!rst && WriteReg) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got reg%0d=%h, expected no write", DstReg, DstData);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({DstReg, DstData} !== e) begin
          errors++;
          $display("FAIL write_order: got reg%0d=%h, expected reg%0d=%h",
                   DstReg, DstData, e[19:16], e[15:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic pw, input logic [3:0] pd, input logic [15:0] pdat,
                     input logic lv, input logic [3:0] ld, input logic [15:0] ldat);
    pipe_we   = pw;
    pipe_dst  = pd;
    pipe_data = pdat;
    ld_valid  = lv;
    ld_dst    = ld;
    ld_data   = ldat;
  endtask

  task automatic idle();
    drv(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_we", 32'(WriteReg), 32'd0);
    chk("rst_dst", 32'(DstReg), 32'd0);
    chk("rst_data", 32'(DstData), 32'd0);
    chk("rst_count", 32'(ld_count), 32'd0);
    chk("rst_pend", 32'(pend_mask), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd1);
    rst = 1'b0;
    step();
    chk("idle_we", 32'(WriteReg), 32'd0);

    // Pipe only
    exp_q.push_back({4'd5, 16'hBEEF});
    drv(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'd0);
    step();
    chk("pipe_we", 32'(WriteReg), 32'd1);
    drv(1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 16'd0);
    step();
    chk("pipe_r0_we", 32'(WriteReg), 32'd0);
    chk("pipe_r0_hold", 32'(DstReg), 32'd5);

    // Load drain
    exp_q.push_back({4'd3, 16'h1111});
    exp_q.push_back({4'd7, 16'h2222});
    drv(1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 16'h1111);
    step();
    chk("drain_pend0", 32'(pend_mask), 32'h0008);
    chk("drain_cnt0", 32'(ld_count), 32'd1);
    drv(1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'h2222);
    step();
    chk("drain_pend1", 32'(pend_mask), 32'h0080);
    chk("drain_cnt1", 32'(ld_count), 32'd1);
    idle();
    step();
    chk("drain_pend2", 32'(pend_mask), 32'h0000);
    chk("drain_cnt2", 32'(ld_count), 32'd0);
    step();
    chk("drain_empty_we", 32'(WriteReg), 32'd0);

    // A load to R0 completes the handshake but is not stored
    drv(1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 16'h7777);
    step();
    chk("r0_load_cnt", 32'(ld_count), 32'd0);

    // Priority over a buffered load
    exp_q.push_back({4'd2, 16'h0202});
    exp_q.push_back({4'd6, 16'h0606});
    exp_q.push_back({4'd4, 16'hAAAA});
    drv(1'b0, 4'd0, 16'd0, 1'b1, 4'd4, 16'hAAAA);
    step();
    drv(1'b1, 4'd2, 16'h0202, 1'b0, 4'd0, 16'd0);
    step();
    chk("prio_cnt1", 32'(ld_count), 32'd1);
    chk("prio_pend1", 32'(pend_mask), 32'h0010);
    drv(1'b1, 4'd6, 16'h0606, 1'b0, 4'd0, 16'd0);
    step();
    chk("prio_cnt2", 32'(ld_count), 32'd1);
    idle();
    step();
    chk("prio_load_we", 32'(WriteReg), 32'd1);
    chk("prio_cnt3", 32'(ld_count), 32'd0);

    // WAW kill
    exp_q.push_back({4'd1, 16'h0101});
    exp_q.push_back({4'd9, 16'h9999});
    exp_q.push_back({4'd10, 16'h5678});
    drv(1'b0, 4'd0, 16'd0, 1'b1, 4'd9, 16'h1234);
    step();
    drv(1'b1, 4'd1, 16'h0101, 1'b1, 4'd10, 16'h5678);
    step();
    chk("waw_pend0", 32'(pend_mask), 32'h0600);
    drv(1'b1, 4'd9, 16'h9999, 1'b1, 4'd9, 16'h4444);
    step();
    chk("waw_pend1", 32'(pend_mask), 32'h0400);
    chk("waw_cnt1", 32'(ld_count), 32'd3);
    idle();
    step();
    chk("waw_bubble1", 32'(WriteReg), 32'd0);
    chk("waw_cnt2", 32'(ld_count), 32'd2);
    step();
    chk("waw_r10_we", 32'(WriteReg), 32'd1);
    chk("waw_pend2", 32'(pend_mask), 32'h0000);
    step();
    chk("waw_bubble2", 32'(WriteReg), 32'd0);
    chk("waw_cnt3", 32'(ld_count), 32'd0);

    // Full and pointer wrap. Loads k=0..6 go to reg k+1 with data C000+k.
    for (int n = 0; n < 4; n++) exp_q.push_back({4'd15, 16'hF000 + 16'(n)});
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back({4'(r + 1), 16'hC000 + 16'(r)});
      exp_q.push_back({4'd15, 16'hE000 + 16'(r)});
    end
    for (int k = 3; k < 7; k++) exp_q.push_back({4'(k + 1), 16'hC000 + 16'(k)});
    for (int n = 0; n < 4; n++) begin
      drv(1'b1, 4'd15, 16'hF000 + 16'(n), 1'b1, 4'(n + 1), 16'hC000 + 16'(n));
      step();
    end
    chk("full_cnt", 32'(ld_count), 32'd4);
    chk("full_ready", 32'(ld_ready), 32'd0);
    chk("full_pend", 32'(pend_mask), 32'h001E);
    for (int r = 0; r < 3; r++) begin
      drv(1'b0, 4'd0, 16'd0, 1'b1, 4'(r + 5), 16'hC000 + 16'(r + 4));
      #1;
      chk("full_pop_ready", 32'(ld_ready), 32'd0);
      step();
      chk("after_pop_ready", 32'(ld_ready), 32'd1);
      chk("after_pop_cnt", 32'(ld_count), 32'd3);
      drv(1'b1, 4'd15, 16'hE000 + 16'(r), 1'b1, 4'(r + 5), 16'hC000 + 16'(r + 4));
      step();
      chk("refill_cnt", 32'(ld_count), 32'd4);
    end
    idle();
    for (int k = 0; k < 4; k++) step();
    chk("wrap_cnt", 32'(ld_count), 32'd0);
    chk("wrap_pend", 32'(pend_mask), 32'h0000);

    // Reset while three entries are buffered
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({4'd15, 16'hD000 + 16'(i)});
      drv(1'b1, 4'd15, 16'hD000 + 16'(i), 1'b1, 4'(11 + i), 16'h0A00 + 16'(i));
      step();
    end
    chk("pre_rst_cnt", 32'(ld_count), 32'd3);
    #5;
    rst = 1'b1;
    #1;
    chk("arst_we", 32'(WriteReg), 32'd0);
    chk("arst_dst", 32'(DstReg), 32'd0);
    chk("arst_cnt", 32'(ld_count), 32'd0);
    chk("arst_pend", 32'(pend_mask), 32'h0000);
    chk("arst_ready", 32'(ld_ready), 32'd1);
    idle();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_we", 32'(WriteReg), 32'd0);
    step();
    chk("post_rst_we2", 32'(WriteReg), 32'd0);
    chk("post_rst_cnt", 32'(ld_count), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
